riscv_fetch: RTL and testbench

- Instruction fetch / PC generation unit for the RV32I core.
- Consumes the ALU's next-PC selection (SRC_PC_PC_4 / SRC_PC_PC_IMM / SRC_PC_RS_IMM) and the operands needed to form the branch or jump target.
- Owns the architectural PC, issues single-outstanding requests to instruction memory, and presents fetched instructions to decode through a valid/ready handshake.

---
 rtl/riscv_fetch_if.sv | 39 +++
 rtl/riscv_fetch.sv | 153 +++++++++++++++
 tb/tb_riscv_fetch.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/riscv_fetch_if.sv
// Fetch-unit signal bundle: execute-stage redirect, instruction-memory port and decode handshake.
// The master modport is the fetch unit; the slave modport is its environment.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef SRC_PC_PC_4
`define SRC_PC_PC_4   2'b00
`define SRC_PC_PC_IMM 2'b01
`define SRC_PC_RS_IMM 2'b10
`endif

interface riscv_fetch_if;
  logic              i_redir_valid;
  logic [1:0]        i_redir_src_pc;
  logic [`XLEN-1:0]  i_redir_pc;
  logic [`XLEN-1:0]  i_redir_imm;
  logic [`XLEN-1:0]  i_redir_rs1;
  logic              o_imem_req;
  logic [`XLEN-1:0]  o_imem_addr;
  logic              i_imem_ack;
  logic [31:0]       i_imem_rdata;
  logic              o_inst_valid;
  logic [31:0]       o_inst;
  logic [`XLEN-1:0]  o_inst_pc;
  logic              i_inst_ready;
  logic              o_misalign_err;

  modport master (
    input  i_redir_valid, i_redir_src_pc, i_redir_pc, i_redir_imm, i_redir_rs1,
    input  i_imem_ack, i_imem_rdata, i_inst_ready,
    output o_imem_req, o_imem_addr, o_inst_valid, o_inst, o_inst_pc, o_misalign_err
  );

  modport slave (
    output i_redir_valid, i_redir_src_pc, i_redir_pc, i_redir_imm, i_redir_rs1,
    output i_imem_ack, i_imem_rdata, i_inst_ready,
    input  o_imem_req, o_imem_addr, o_inst_valid, o_inst, o_inst_pc, o_misalign_err
  );
endinterface

// File: rtl/riscv_fetch.sv
// RV32I PC generation / fetch, single outstanding imem request; RISCV_FETCH_MISALIGN_CHK_EN adds S_ERR trap.
// Latency: first request 1 cycle after reset release, instruction valid 1 cycle after ack (1 instr / 2 cycles).
// Backpressure: holds the buffered instruction while i_inst_ready=0; a redirect always wins over ready.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef SRC_PC_PC_4
`define SRC_PC_PC_4   2'b00
`define SRC_PC_PC_IMM 2'b01
`define SRC_PC_RS_IMM 2'b10
`endif

module riscv_fetch #(
  parameter logic [`XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic          i_clk,
  input  logic          i_rstn,
  riscv_fetch_if.master bus
);

  typedef enum logic [2:0] {
    S_BOOT,
    S_REQ,
    S_FLUSH,
    S_VALID
`ifdef RISCV_FETCH_MISALIGN_CHK_EN
    , S_ERR
`endif
  } state_t;

  localparam logic [31:0] NOP = 32'h0000_0013;

  state_t           state_q, state_d;
  logic [`XLEN-1:0] pc_q, pc_d;
  logic [`XLEN-1:0] tgt_q, tgt_d;
  logic [31:0]      inst_q, inst_d;
  logic [`XLEN-1:0] inst_pc_q, inst_pc_d;

  logic             redir_take;
  logic             is_rs;
  logic [`XLEN-1:0] target;
  logic [`XLEN-1:0] flush_tgt;
  state_t           jump_state;
  state_t           flush_state;

  always_comb begin
    is_rs      = (bus.i_redir_src_pc == `SRC_PC_RS_IMM);
    redir_take = bus.i_redir_valid &&
                 ((bus.i_redir_src_pc == `SRC_PC_PC_IMM) || is_rs);
    target     = (is_rs ? bus.i_redir_rs1 : bus.i_redir_pc) + bus.i_redir_imm;
    if (is_rs) begin
      target[0] = 1'b0;
    end
`ifndef RISCV_FETCH_MISALIGN_CHK_EN
    target[1:0] = 2'b00;
`endif
    // In S_FLUSH a redirect arriving with the ack still takes precedence.
    flush_tgt = redir_take ? target : tgt_q;
`ifdef RISCV_FETCH_MISALIGN_CHK_EN
    jump_state  = target[1]    ? S_ERR : S_REQ;
    flush_state = flush_tgt[1] ? S_ERR : S_REQ;
`else
    jump_state  = S_REQ;
    flush_state = S_REQ;
`endif
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    tgt_d     = tgt_q;
    inst_d    = inst_q;
    inst_pc_d = inst_pc_q;
    case (state_q)
      S_BOOT: begin
        state_d = S_REQ;
      end
      S_REQ: begin
        if (bus.i_imem_ack) begin
          if (redir_take) begin
            pc_d    = target;
            state_d = jump_state;
          end else begin
            inst_d    = bus.i_imem_rdata;
            inst_pc_d = pc_q;
            state_d   = S_VALID;
          end
        end else if (redir_take) begin
          tgt_d   = target;
          state_d = S_FLUSH;
        end
      end
      S_FLUSH: begin
        if (redir_take) begin
          tgt_d = target;
        end
        if (bus.i_imem_ack) begin
          pc_d    = flush_tgt;
          state_d = flush_state;
        end
      end
      S_VALID: begin
        if (redir_take) begin
          pc_d    = target;
          state_d = jump_state;
        end else if (bus.i_inst_ready) begin
          pc_d    = pc_q + `XLEN'(4);
          state_d = S_REQ;
        end
      end
`ifdef RISCV_FETCH_MISALIGN_CHK_EN
      S_ERR: begin
        if (redir_take) begin
          pc_d    = target;
          state_d = jump_state;
        end
      end
`endif
      default: begin
        state_d = S_BOOT;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q   <= S_BOOT;
      pc_q      <= RESET_PC;
      tgt_q     <= RESET_PC;
      inst_q    <= NOP;
      inst_pc_q <= RESET_PC;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      tgt_q     <= tgt_d;
      inst_q    <= inst_d;
      inst_pc_q <= inst_pc_d;
    end
  end

  assign bus.o_imem_req   = (state_q == S_REQ) || (state_q == S_FLUSH);
  assign bus.o_imem_addr  = pc_q;
  assign bus.o_inst_valid = (state_q == S_VALID);
  assign bus.o_inst       = inst_q;
  assign bus.o_inst_pc    = inst_pc_q;
`ifdef RISCV_FETCH_MISALIGN_CHK_EN
  // S_ERR is only entered on a misaligned target and only left on an aligned one.
  assign bus.o_misalign_err = (state_q == S_ERR);
`else
  assign bus.o_misalign_err = 1'b0;
`endif

endmodule

// File: tb/tb_riscv_fetch.sv
// Bench for riscv_fetch: per-cycle vector table plus an instruction scoreboard and reset/boot sequences.
module tb_riscv_fetch;

  localparam logic [31:0] RST_PC = 32'h0000_0100;
  localparam logic [1:0]  PC4    = 2'b00;
  localparam logic [1:0]  PCIMM  = 2'b01;
  localparam logic [1:0]  RSIMM  = 2'b10;
  localparam logic [1:0]  UNUSED = 2'b11;

  logic i_clk = 1'b0;
  logic i_rstn;
  always #5 i_clk = ~i_clk;

  riscv_fetch_if bus ();

  riscv_fetch #(.RESET_PC(RST_PC)) dut (
    .i_clk (i_clk),
    .i_rstn(i_rstn),
    .bus   (bus)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5EED_0003;
  endfunction

  always_comb bus.i_imem_rdata = mem_word(bus.o_imem_addr);

  typedef struct {
    logic        ack;
    logic        rdy;
    logic        rv;
    logic [1:0]  src;
    logic [31:0] rpc;
    logic [31:0] imm;
    logic [31:0] rs1;
    logic        fetch;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_vld;
    logic        exp_err;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] sb_inst[$];
  logic [31:0] sb_pc[$];
  logic [31:0] cur_inst;
  logic [31:0] cur_pc;
  logic        prev_vld;
  int          errors = 0;
  int          checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic ack, input logic rdy, input logic rv, input logic [1:0] src,
                     input logic [31:0] rpc, input logic [31:0] imm, input logic [31:0] rs1,
                     input logic fetch, input logic req, input logic [31:0] addr,
                     input logic vld, input logic err);
    vec_t v;
    v = '{ack, rdy, rv, src, rpc, imm, rs1, fetch, req, addr, vld, err};
    vecs.push_back(v);
  endtask

  task automatic nr(input logic ack, input logic rdy, input logic fetch,
                    input logic req, input logic [31:0] addr, input logic vld);
    add(ack, rdy, 1'b0, PC4, 32'h0, 32'h0, 32'h0, fetch, req, addr, vld, 1'b0);
  endtask

  task automatic drive(input vec_t v);
    bus.i_imem_ack     = v.ack;
    bus.i_inst_ready   = v.rdy;
    bus.i_redir_valid  = v.rv;
    bus.i_redir_src_pc = v.src;
    bus.i_redir_pc     = v.rpc;
    bus.i_redir_imm    = v.imm;
    bus.i_redir_rs1    = v.rs1;
  endtask

  // New instruction on a rising valid pops the scoreboard; while valid stays high it must hold.
  task automatic sb_check(input string tag);
    if (bus.o_inst_valid && !prev_vld) begin
      if (sb_inst.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL %s_sb_underflow: got valid instr pc %h expected none", tag, bus.o_inst_pc);
      end else begin
        cur_inst = sb_inst.pop_front();
        cur_pc   = sb_pc.pop_front();
      end
    end
    if (bus.o_inst_valid) begin
      chk({tag, "_inst"}, bus.o_inst, cur_inst);
      chk({tag, "_inst_pc"}, bus.o_inst_pc, cur_pc);
    end
    prev_vld = bus.o_inst_valid;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t        v;
    vec_t        idle;
    logic [31:0] cur_addr;
    logic        err_exp;
    logic [31:0] mis_addr;
    logic        mis_req;

    idle = '{1'b0, 1'b0, 1'b0, PC4, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0};
    drive(idle);
    i_rstn   = 1'b0;
    prev_vld = 1'b0;
    cur_inst = 32'h0;
    cur_pc   = 32'h0;

`ifdef RISCV_FETCH_MISALIGN_CHK_EN
    err_exp  = 1'b1;
    mis_addr = 32'h402;
    mis_req  = 1'b0;
`else
    err_exp  = 1'b0;
    mis_addr = 32'h400;
    mis_req  = 1'b1;
`endif

    // ack, rdy, fetch, exp req, exp addr, exp valid
    nr(1, 1, 0, 1, 32'h100, 0);                  // boot -> first request
    nr(1, 1, 1, 0, 32'h100, 1);
    nr(1, 1, 0, 1, 32'h104, 0);
    nr(1, 1, 1, 0, 32'h104, 1);
    nr(1, 1, 0, 1, 32'h108, 0);
    nr(1, 1, 1, 0, 32'h108, 1);
    for (int k = 0; k < 5; k++) nr(1, 0, 0, 0, 32'h108, 1);  // decode stall
    nr(1, 1, 0, 1, 32'h10C, 0);
    nr(1, 1, 1, 0, 32'h10C, 1);
    add(1, 1, 1, PCIMM, 32'h200, 32'hFFFF_FFF0, 32'h0, 0, 1, 32'h1F0, 0, 0);
    nr(1, 1, 1, 0, 32'h1F0, 1);
    nr(1, 1, 0, 1, 32'h1F4, 0);
    add(0, 1, 1, RSIMM, 32'h0, 32'h4, 32'h301, 0, 1, 32'h1F4, 0, 0);
    nr(0, 1, 0, 1, 32'h1F4, 0);
    nr(0, 1, 0, 1, 32'h1F4, 0);
    nr(1, 1, 0, 1, 32'h304, 0);                  // flushed data discarded
    nr(1, 1, 1, 0, 32'h304, 1);
    add(1, 0, 1, PC4, 32'h200, 32'hFFFF_FFF0, 32'h0, 0, 0, 32'h304, 1, 0);
    add(1, 1, 1, PC4, 32'h200, 32'hFFFF_FFF0, 32'h0, 0, 1, 32'h308, 0, 0);
    add(1, 1, 1, PC4, 32'h200, 32'hFFFF_FFF0, 32'h0, 1, 0, 32'h308, 1, 0);
    add(1, 1, 1, UNUSED, 32'h200, 32'hFFFF_FFF0, 32'h0, 0, 1, 32'h30C, 0, 0);
    add(1, 1, 1, PCIMM, 32'h600, 32'h20, 32'h0, 0, 1, 32'h620, 0, 0);
    nr(0, 1, 0, 1, 32'h620, 0);
    nr(1, 1, 1, 0, 32'h620, 1);
    nr(1, 1, 0, 1, 32'h624, 0);
    add(0, 1, 1, PCIMM, 32'h700, 32'h0, 32'h0, 0, 1, 32'h624, 0, 0);
    add(0, 1, 1, RSIMM, 32'h0, 32'h10, 32'h800, 0, 1, 32'h624, 0, 0);
    nr(1, 1, 0, 1, 32'h810, 0);                  // last redirect wins
    nr(1, 1, 1, 0, 32'h810, 1);
    add(1, 0, 1, PCIMM, 32'hFFFF_FFF0, 32'hC, 32'h0, 0, 1, 32'hFFFF_FFFC, 0, 0);
    nr(1, 1, 1, 0, 32'hFFFF_FFFC, 1);
    nr(1, 1, 0, 1, 32'h0, 0);                    // pc+4 wrap
    nr(1, 1, 1, 0, 32'h0, 1);
    add(1, 1, 1, PCIMM, 32'h400, 32'h2, 32'h0, 0, mis_req, mis_addr, 0, err_exp);
    add(0, 1, 0, PC4, 32'h0, 32'h0, 32'h0, 0, mis_req, mis_addr, 0, err_exp);
    add(1, 1, 1, PCIMM, 32'h500, 32'h0, 32'h0, 0, 1, 32'h500, 0, 0);
    nr(1, 1, 1, 0, 32'h500, 1);

    repeat (2) @(posedge i_clk);
    #1;
    chk("rst_req", {31'h0, bus.o_imem_req}, 32'h0);
    chk("rst_addr", bus.o_imem_addr, RST_PC);
    chk("rst_vld", {31'h0, bus.o_inst_valid}, 32'h0);
    chk("rst_inst", bus.o_inst, 32'h0000_0013);
    chk("rst_inst_pc", bus.o_inst_pc, RST_PC);
    chk("rst_err", {31'h0, bus.o_misalign_err}, 32'h0);
    i_rstn = 1'b1;

    cur_addr = RST_PC;
    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      drive(v);
      if (v.fetch) begin
        sb_inst.push_back(mem_word(cur_addr));
        sb_pc.push_back(cur_addr);
      end
      @(posedge i_clk);
      #1;
      chk($sformatf("v%0d_req", i), {31'h0, bus.o_imem_req}, {31'h0, v.exp_req});
      chk($sformatf("v%0d_addr", i), bus.o_imem_addr, v.exp_addr);
      chk($sformatf("v%0d_vld", i), {31'h0, bus.o_inst_valid}, {31'h0, v.exp_vld});
      chk($sformatf("v%0d_err", i), {31'h0, bus.o_misalign_err}, {31'h0, v.exp_err});
      sb_check($sformatf("v%0d", i));
      cur_addr = v.exp_addr;
    end
    chk("sb_empty", sb_inst.size(), 32'h0);

    // Asynchronous reset mid-cycle, then a redirect during boot must be ignored.
    drive(idle);
    #2;
    i_rstn = 1'b0;
    #1;
    chk("arst_req", {31'h0, bus.o_imem_req}, 32'h0);
    chk("arst_addr", bus.o_imem_addr, RST_PC);
    chk("arst_vld", {31'h0, bus.o_inst_valid}, 32'h0);
    chk("arst_inst", bus.o_inst, 32'h0000_0013);
    chk("arst_inst_pc", bus.o_inst_pc, RST_PC);
    @(posedge i_clk);
    #1;
    i_rstn = 1'b1;
    v = idle;
    v.ack = 1'b1; v.rdy = 1'b1; v.rv = 1'b1; v.src = PCIMM; v.rpc = 32'h900;
    drive(v);
    @(posedge i_clk);
    #1;
    chk("boot_redir_req", {31'h0, bus.o_imem_req}, 32'h1);
    chk("boot_redir_addr", bus.o_imem_addr, RST_PC);
    v.rv = 1'b0;
    drive(v);
    @(posedge i_clk);
    #1;
    chk("boot_vld", {31'h0, bus.o_inst_valid}, 32'h1);
    chk("boot_inst", bus.o_inst, mem_word(RST_PC));
    chk("boot_inst_pc", bus.o_inst_pc, RST_PC);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
